// File: rtl/mac_cluster_stream.sv
// Streaming LANES-wide MAC cluster: valid/ready beats, programmable dot-product length.
// Define MAC_SAT_EN for saturating accumulation (default: modulo wrap).
module mac_cluster_stream #(
  parameter int LANES = 4,
  parameter int IN_W  = 8,
  parameter int ACC_W = 32,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   cset,
  input  logic                   cfg_signed,
  input  logic                   cfg_mac,
  input  logic [CNT_W-1:0]       cfg_len,
  input  logic [LANES*ACC_W-1:0] cfg_init,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  a,
  input  logic [LANES*IN_W-1:0]  b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*ACC_W-1:0] out,
  output logic                   busy
);

  localparam int PW = 2 * IN_W;
  localparam int AW = LANES * ACC_W;

  logic             sgn_q, sgn_d;
  logic             mac_q, mac_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [AW-1:0]    init_q, init_d;
  logic             s1_valid_q, s1_valid_d;
  logic [AW-1:0]    s1_q, s1_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [AW-1:0]    out_q, out_d;

  logic [AW-1:0] prod;
  logic [AW-1:0] sum;
  logic          stall, adv, accept, last;

  assign stall    = out_valid_q & ~out_ready;
  assign adv      = en & ~stall;
  assign in_ready = adv & ~cset;
  assign accept   = in_valid & in_ready;
  // len 0 behaves as len 1: every beat closes the group
  assign last     = (len_q == '0) || (cnt_q == len_q - CNT_W'(1));

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign busy      = s1_valid_q | (cnt_q != '0);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [PW-1:0]    ax, bx, pr;
    logic [ACC_W-1:0] acc_l, s1_l, sum_l;

    assign ax = {{IN_W{sgn_q & a[i*IN_W+IN_W-1]}}, a[i*IN_W +: IN_W]};
    assign bx = {{IN_W{sgn_q & b[i*IN_W+IN_W-1]}}, b[i*IN_W +: IN_W]};
    assign pr = ax * bx;

    if (ACC_W > PW) begin : g_ext
      assign prod[i*ACC_W +: ACC_W] =
        {{(ACC_W-PW){sgn_q & pr[PW-1]}}, pr};
    end else begin : g_noext
      assign prod[i*ACC_W +: ACC_W] = pr;
    end

    assign acc_l = acc_q[i*ACC_W +: ACC_W];
    assign s1_l  = s1_q[i*ACC_W +: ACC_W];

`ifdef MAC_SAT_EN
    logic [ACC_W:0] ws;

    // one guard bit: sign extension when signed, carry when unsigned
    assign ws = {sgn_q & acc_l[ACC_W-1], acc_l}
              + {sgn_q & s1_l[ACC_W-1], s1_l};

    always_comb begin
      sum_l = ws[ACC_W-1:0];
      if (sgn_q && (ws[ACC_W] != ws[ACC_W-1]))
        sum_l = {ws[ACC_W], {(ACC_W-1){~ws[ACC_W]}}};
      else if (!sgn_q && ws[ACC_W])
        sum_l = '1;
    end
`else
    assign sum_l = acc_l + s1_l;
`endif

    assign sum[i*ACC_W +: ACC_W] = sum_l;
  end

  always_comb begin
    sgn_d       = sgn_q;
    mac_d       = mac_q;
    len_d       = len_q;
    init_d      = init_q;
    s1_valid_d  = s1_valid_q;
    s1_d        = s1_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (cset) begin
      sgn_d       = cfg_signed;
      mac_d       = cfg_mac;
      len_d       = cfg_len;
      init_d      = cfg_init;
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
      acc_d       = cfg_init;
      cnt_d       = '0;
    end else begin
      if (out_valid_q && out_ready)
        out_valid_d = 1'b0;
      if (adv) begin
        s1_valid_d = accept;
        if (accept)
          s1_d = prod;
        if (s1_valid_q) begin
          if (mac_q) begin
            if (last) begin
              out_d       = sum;
              out_valid_d = 1'b1;
              acc_d       = init_q;
              cnt_d       = '0;
            end else begin
              acc_d = sum;
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            out_d       = s1_q;
            out_valid_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sgn_q       <= 1'b0;
      mac_q       <= 1'b0;
      len_q       <= CNT_W'(1);
      init_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      sgn_q       <= sgn_d;
      mac_q       <= mac_d;
      len_q       <= len_d;
      init_q      <= init_d;
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

endmodule

// File: tb/tb_mac_cluster_stream.sv
// Bench for mac_cluster_stream: vector table, corner sequences, random traffic.
// Reference model works on whole dot-product groups at beat acceptance time.
module tb_mac_cluster_stream;

  localparam int LANES = 4;
  localparam int IN_W  = 8;
  localparam int ACC_W = 32;
  localparam int CNT_W = 8;
  localparam int AW    = LANES * ACC_W;
  localparam int BW    = LANES * IN_W;
  localparam longint FULL = longint'(1) << ACC_W;
  localparam longint HALF = FULL / 2;
  localparam longint MASK = FULL - 1;

  typedef struct {
    bit               sgn;
    bit               mac;
    int               len;
    logic [ACC_W-1:0] init;
    logic [IN_W-1:0]  av;
    logic [IN_W-1:0]  bv;
    int               nbeats;
    int               nres;
    logic [ACC_W-1:0] res;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst, en, cset, cfg_signed, cfg_mac;
  logic [CNT_W-1:0] cfg_len;
  logic [AW-1:0]    cfg_init;
  logic             in_valid, in_ready;
  logic [BW-1:0]    a, b;
  logic             out_valid, out_ready;
  logic [AW-1:0]    out;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  int cyc    = 0;
  int pop_cyc[$];
  logic [AW-1:0] last_out;
  logic [AW-1:0] exp_q[$];

  bit     m_sgn, m_mac;
  int     m_len, m_cnt;
  longint m_acc[LANES];
  longint m_init[LANES];

  vec_t tbl[10];

  mac_cluster_stream #(
    .LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .cset(cset),
    .cfg_signed(cfg_signed), .cfg_mac(cfg_mac),
    .cfg_len(cfg_len), .cfg_init(cfg_init),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [AW-1:0] act,
                     input logic [AW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  function automatic logic [AW-1:0] bcast(input logic [ACC_W-1:0] v);
    logic [AW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*ACC_W +: ACC_W] = v;
    return r;
  endfunction

  function automatic logic [BW-1:0] bop(input logic [IN_W-1:0] v);
    logic [BW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*IN_W +: IN_W] = v;
    return r;
  endfunction

  function automatic longint prod_f(input bit s, input logic [IN_W-1:0] x,
                                    input logic [IN_W-1:0] y);
    longint xi, yi;
    xi = longint'(x);
    yi = longint'(y);
    if (s && x[IN_W-1]) xi -= (longint'(1) << IN_W);
    if (s && y[IN_W-1]) yi -= (longint'(1) << IN_W);
    return xi * yi;
  endfunction

  function automatic longint accum_f(input longint acc_u, input longint p);
    longint v;
`ifdef MAC_SAT_EN
    if (m_sgn) begin
      v = acc_u;
      if (v >= HALF) v -= FULL;
      v += p;
      if (v > HALF - 1) v = HALF - 1;
      else if (v < -HALF) v = -HALF;
    end else begin
      v = acc_u + p;
      if (v > MASK) v = MASK;
    end
`else
    v = acc_u + p;
`endif
    return v & MASK;
  endfunction

  task automatic model_reset();
    m_sgn = 1'b0; m_mac = 1'b0; m_len = 1; m_cnt = 0;
    for (int l = 0; l < LANES; l++) begin
      m_init[l] = 0;
      m_acc[l]  = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_cset();
    m_sgn = cfg_signed;
    m_mac = cfg_mac;
    m_len = (cfg_len == '0) ? 1 : int'(cfg_len);
    m_cnt = 0;
    for (int l = 0; l < LANES; l++) begin
      m_init[l] = longint'(cfg_init[l*ACC_W +: ACC_W]);
      m_acc[l]  = m_init[l];
    end
  endtask

  task automatic model_beat();
    logic [AW-1:0] r;
    longint p, s;
    bit fin;
    fin = m_mac && (m_cnt == m_len - 1);
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      p = prod_f(m_sgn, a[l*IN_W +: IN_W], b[l*IN_W +: IN_W]);
      if (m_mac) begin
        s = accum_f(m_acc[l], p);
        m_acc[l] = fin ? m_init[l] : s;
      end else begin
        s = p & MASK;
      end
      r[l*ACC_W +: ACC_W] = s[ACC_W-1:0];
    end
    if (!m_mac || fin) exp_q.push_back(r);
    if (m_mac) m_cnt = fin ? 0 : m_cnt + 1;
  endtask

  // scoreboard: results popped this cycle, then model update for this edge
  always @(negedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      if (out_valid && out_ready) begin
        pops++;
        pop_cyc.push_back(cyc);
        last_out = out;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream_extra: got %h required no result", out);
        end else begin
          chk("stream_out", out, exp_q.pop_front());
        end
      end
      if (cset) begin
        chk("cset_drained", exp_q.size(), 0);
        model_cset();
      end else if (in_valid && in_ready) begin
        model_beat();
      end
    end
  end

  task automatic do_cset(input bit s, input bit m, input int len,
                         input logic [AW-1:0] iv);
    cset = 1'b1; cfg_signed = s; cfg_mac = m;
    cfg_len = CNT_W'(len); cfg_init = iv;
    @(posedge clk); #1;
    cset = 1'b0; cfg_signed = ~s; cfg_mac = ~m;
    cfg_len = CNT_W'($urandom);
    for (int l = 0; l < LANES; l++)
      cfg_init[l*ACC_W +: ACC_W] = ACC_W'($urandom);
  endtask

  task automatic send(input logic [BW-1:0] av, input logic [BW-1:0] bv);
    int t;
    t = 0;
    in_valid = 1'b1; a = av; b = bv;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout: in_ready got 0 required 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [AW-1:0] v;
    logic [BW-1:0] av, bv;
    int p0;
    bit pend;

    rst = 1'b1; en = 1'b1; cset = 1'b0;
    cfg_signed = 1'b0; cfg_mac = 1'b0; cfg_len = '0; cfg_init = '0;
    in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;

    tbl[0] = '{0, 1, 4, 32'h0, 8'd3, 8'd5, 4, 1, 32'd60};
    tbl[1] = '{1, 1, 2, 32'd100, 8'hFE, 8'd7, 4, 2, 32'd72};
    tbl[2] = '{0, 0, 1, 32'h0, 8'hFF, 8'hFF, 5, 5, 32'd65025};
    tbl[3] = '{1, 0, 1, 32'h0, 8'h80, 8'h80, 2, 2, 32'd16384};
    tbl[4] = '{1, 0, 1, 32'h0, 8'h80, 8'h7F, 1, 1, 32'hFFFFC080};
    tbl[5] = '{0, 1, 0, 32'd10, 8'd2, 8'd3, 3, 3, 32'd16};
    tbl[6] = '{1, 1, 3, 32'hFFFFFFFF, 8'hFF, 8'h01, 3, 1, 32'hFFFFFFFC};
    tbl[9] = '{0, 0, 1, 32'h0, 8'hFE, 8'd7, 1, 1, 32'd1778};
`ifdef MAC_SAT_EN
    tbl[7] = '{1, 1, 2, 32'h7FFFFFF0, 8'd127, 8'd127, 2, 1, 32'h7FFFFFFF};
    tbl[8] = '{0, 1, 2, 32'hFFFFFFF0, 8'h10, 8'h01, 2, 1, 32'hFFFFFFFF};
`else
    tbl[7] = '{1, 1, 2, 32'h7FFFFFF0, 8'd127, 8'd127, 2, 1, 32'h80007DF2};
    tbl[8] = '{0, 1, 2, 32'hFFFFFFF0, 8'h10, 8'h01, 2, 1, 32'h00000010};
`endif

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, '0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // cfg inputs change without cset: reset cfg (unsigned multiply) must hold
    cfg_signed = 1'b1; cfg_mac = 1'b1; cfg_len = 8'd3;
    send(bop(8'hFF), bop(8'h02));
    idle(4);
    chk("rst_cfg_result", last_out, bcast(32'd510));

    // latency / single pulse / busy for a 4-beat group
    do_cset(0, 1, 4, '0);
    av = '0; bv = '0;
    av[IN_W-1:0] = 8'd3;
    bv[IN_W-1:0] = 8'd5;
    repeat (4) send(av, bv);
    v = '0;
    v[ACC_W-1:0] = 32'd60;
    @(negedge clk);
    chk("lat_edge1_valid", out_valid, 0);
    chk("lat_edge1_busy", busy, 1);
    @(negedge clk);
    chk("lat_edge2_valid", out_valid, 1);
    chk("lat_edge2_out", out, v);
    chk("lat_edge2_busy", busy, 0);
    @(negedge clk);
    chk("lat_single_pulse", out_valid, 0);
    @(posedge clk); #1;

    for (int r = 0; r < 10; r++) begin
      p0 = pops;
      do_cset(tbl[r].sgn, tbl[r].mac, tbl[r].len, bcast(tbl[r].init));
      repeat (tbl[r].nbeats) send(bop(tbl[r].av), bop(tbl[r].bv));
      idle(5);
      chk($sformatf("tbl%0d_count", r), pops - p0, tbl[r].nres);
      chk($sformatf("tbl%0d_value", r), last_out, bcast(tbl[r].res));
      if (!tbl[r].mac && pops > p0)
        chk($sformatf("tbl%0d_back2back", r),
            pop_cyc[pops-1] - pop_cyc[p0], tbl[r].nres - 1);
    end

    // cset with half a group accumulated discards it
    do_cset(0, 1, 4, bcast(32'd7));
    repeat (2) send(bop(8'd2), bop(8'd3));
    idle(3);
    chk("partial_busy", busy, 1);
    p0 = pops;
    do_cset(0, 1, 4, bcast(32'd1000));
    @(negedge clk);
    chk("partial_cset_valid", out_valid, 0);
    chk("partial_cset_busy", busy, 0);
    @(posedge clk); #1;
    repeat (4) send(bop(8'd2), bop(8'd3));
    idle(5);
    chk("partial_count", pops - p0, 1);
    chk("partial_value", last_out, bcast(32'd1024));

    // back-pressure: results held, input throttled, nothing lost
    do_cset(0, 0, 1, '0);
    p0 = pops;
    for (int l = 0; l < LANES; l++) v[l*ACC_W +: ACC_W] = ACC_W'((l + 1) * 16);
    out_ready = 1'b0;
    fork
      for (int i = 0; i < 4; i++) begin
        logic [BW-1:0] op;
        for (int l = 0; l < LANES; l++) op[l*IN_W +: IN_W] = IN_W'(l + 1 + i);
        send(op, bop(8'h10));
      end
      begin
        repeat (6) @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_out_hold", out, v);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    idle(5);
    chk("bp_count", pops - p0, 4);
    chk("bp_all_delivered", exp_q.size(), 0);

    // random traffic with en gaps and back-pressure
    for (int k = 0; k < 4; k++) begin
      for (int l = 0; l < LANES; l++)
        v[l*ACC_W +: ACC_W] = ($urandom_range(0, 1) == 1) ?
          ACC_W'($urandom) : {1'b0, {(ACC_W-9){1'b1}}, 8'h00};
      do_cset(1'($urandom), 1'($urandom), $urandom_range(0, 5), v);
      pend = 1'b0;
      for (int c = 0; c < 250; c++) begin
        en = ($urandom_range(0, 9) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        if (!pend) begin
          in_valid = ($urandom_range(0, 9) < 7);
          a = BW'($urandom);
          b = BW'($urandom);
        end
        @(negedge clk);
        pend = in_valid && !in_ready;
        @(posedge clk); #1;
      end
      en = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
      idle(6);
      chk($sformatf("rnd%0d_drained", k), exp_q.size(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

endmodule
